// File: rtl/bf_program_loader_if.sv
// rtl/bf_program_loader_if.sv - UART byte input and program SRAM write bus for the loader
interface bf_program_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;

   // Loader side: consumes received bytes, drives the SRAM write port
   modport master (
      input  rx_data,
      input  rx_valid,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   // Environment side: UART receiver and program SRAM
   modport slave (
      output rx_data,
      output rx_valid,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/bf_program_loader.sv
// rtl/bf_program_loader.sv - filters UART bytes into Brainfuck program SRAM; optional macro BF_LOADER_BRACKET_CHECK_EN
module bf_program_loader #(
   parameter int         ADDR_WIDTH  = 10,
   parameter logic [7:0] TERM_BYTE   = 8'h21,
   parameter int         DEPTH_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   bf_program_loader_if.master   bus,
   output logic                  loading,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] prog_len,
   output logic                  error,
   output logic [1:0]            error_code
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      FINISH = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   // Last slot is kept free for the terminator
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
`ifdef BF_LOADER_BRACKET_CHECK_EN
   localparam logic [1:0] ERR_UNMATCH  = 2'd2;
   localparam logic [1:0] ERR_UNCLOSED = 2'd3;
`endif

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] count, count_nxt;
   logic                  we_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [7:0]            wdata_nxt;
   logic [ADDR_WIDTH-1:0] prog_len_nxt;
   logic [1:0]            error_code_nxt;
   logic                  is_cmd;

`ifdef BF_LOADER_BRACKET_CHECK_EN
   localparam logic [DEPTH_WIDTH-1:0] DEPTH_ZERO = '0;
   localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE  = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX  = '1;
   logic [DEPTH_WIDTH-1:0] depth, depth_nxt;
`else
   // Without bracket checking the nesting width has no hardware; the empty
   // block only keeps the parameter referenced so builds stay interchangeable.
   if (DEPTH_WIDTH < 1) begin : g_depth_width_unused
   end
`endif

   // Classify the incoming byte as one of the eight command characters
   always_comb begin
      is_cmd = 1'b0;
      case (bus.rx_data)
         8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
         default: is_cmd = 1'b0;
      endcase
   end

   // State register and registered SRAM/status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         count         <= ADDR_ZERO;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= ADDR_ZERO;
         bus.mem_wdata <= 8'h00;
         prog_len      <= ADDR_ZERO;
         error_code    <= ERR_NONE;
`ifdef BF_LOADER_BRACKET_CHECK_EN
         depth         <= DEPTH_ZERO;
`endif
      end else begin
         state         <= state_nxt;
         count         <= count_nxt;
         bus.mem_we    <= we_nxt;
         bus.mem_addr  <= addr_nxt;
         bus.mem_wdata <= wdata_nxt;
         prog_len      <= prog_len_nxt;
         error_code    <= error_code_nxt;
`ifdef BF_LOADER_BRACKET_CHECK_EN
         depth         <= depth_nxt;
`endif
      end
   end

   // Next-state and next-output decode; start overrides everything, dropping any coincident byte
   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      we_nxt         = 1'b0;
      addr_nxt       = bus.mem_addr;
      wdata_nxt      = bus.mem_wdata;
      prog_len_nxt   = prog_len;
      error_code_nxt = error_code;
`ifdef BF_LOADER_BRACKET_CHECK_EN
      depth_nxt      = depth;
`endif

      if (start) begin
         state_nxt      = LOAD;
         count_nxt      = ADDR_ZERO;
         prog_len_nxt   = ADDR_ZERO;
         error_code_nxt = ERR_NONE;
`ifdef BF_LOADER_BRACKET_CHECK_EN
         depth_nxt      = DEPTH_ZERO;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (bus.rx_valid) begin
                  if (is_cmd) begin
                     if (count == ADDR_LAST) begin
                        state_nxt      = ERROR;
                        error_code_nxt = ERR_OVERFLOW;
                     end
`ifdef BF_LOADER_BRACKET_CHECK_EN
                     else if (bus.rx_data == 8'h5D && depth == DEPTH_ZERO) begin
                        state_nxt      = ERROR;
                        error_code_nxt = ERR_UNMATCH;
                     end else if (bus.rx_data == 8'h5B && depth == DEPTH_MAX) begin
                        state_nxt      = ERROR;
                        error_code_nxt = ERR_OVERFLOW;
                     end
`endif
                     else begin
                        we_nxt    = 1'b1;
                        addr_nxt  = count;
                        wdata_nxt = bus.rx_data;
                        count_nxt = count + ADDR_ONE;
`ifdef BF_LOADER_BRACKET_CHECK_EN
                        if (bus.rx_data == 8'h5B) begin
                           depth_nxt = depth + DEPTH_ONE;
                        end else if (bus.rx_data == 8'h5D) begin
                           depth_nxt = depth - DEPTH_ONE;
                        end
`endif
                     end
                  end else if (bus.rx_data == TERM_BYTE) begin
`ifdef BF_LOADER_BRACKET_CHECK_EN
                     if (depth != DEPTH_ZERO) begin
                        state_nxt      = ERROR;
                        error_code_nxt = ERR_UNCLOSED;
                     end else begin
                        state_nxt = FINISH;
                     end
`else
                     state_nxt = FINISH;
`endif
                  end
               end
            end
            FINISH: begin
               we_nxt       = 1'b1;
               addr_nxt     = count;
               wdata_nxt    = 8'h00;
               prog_len_nxt = count;
               state_nxt    = DONE;
            end
            default: begin
               state_nxt = state;
            end
         endcase
      end
   end

   // Status flags follow the state directly
   always_comb begin
      loading = (state == LOAD) || (state == FINISH);
      done    = (state == DONE);
      error   = (state == ERROR);
   end

endmodule

// File: tb/tb_bf_program_loader.sv
// tb/tb_bf_program_loader.sv - scoreboard bench for bf_program_loader
module tb_bf_program_loader;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          loading;
   logic          done;
   logic [AW-1:0] prog_len;
   logic          error;
   logic [1:0]    error_code;

   int checks   = 0;
   int failures = 0;

   logic [AW+7:0] exp_q[$];

   bf_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

   bf_program_loader #(.ADDR_WIDTH(AW)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .loading    (loading),
      .done       (done),
      .prog_len   (prog_len),
      .error      (error),
      .error_code (error_code)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every SRAM write must match the oldest expected write
   always @(negedge clock) begin
      if (!reset && bus.mem_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got %0h@%0d expected none", bus.mem_wdata, bus.mem_addr);
         end else begin
            logic [AW+7:0] e;
            e = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== e) begin
               failures++;
               $display("FAIL write: got %0h@%0d expected %0h@%0d",
                        bus.mem_wdata, bus.mem_addr, e[7:0], e[AW+7:8]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_wr(input int addr, input logic [7:0] data);
      logic [AW-1:0] a;
      a = addr[AW-1:0];
      exp_q.push_back({a, data});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         bus.rx_data  = s[i];
         bus.rx_valid = 1'b1;
         tick();
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_end(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done || error) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk({name, "_reached_end"}, int'(seen), 1);
      @(negedge clock);
      #1;
      chk({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      chk("rst_mem_we", int'(bus.mem_we), 0);
      chk("rst_mem_addr", int'(bus.mem_addr), 0);
      chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
      chk("rst_loading", int'(loading), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_prog_len", int'(prog_len), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_error_code", int'(error_code), 0);

      // "+[-]!" stored in order with terminator at 4
      pulse_start();
      chk("t1_loading", int'(loading), 1);
      expect_wr(0, 8'h2B);
      expect_wr(1, 8'h5B);
      expect_wr(2, 8'h2D);
      expect_wr(3, 8'h5D);
      expect_wr(4, 8'h00);
      send_str("+[-]!");
      wait_end("t1");
      chk("t1_done", int'(done), 1);
      chk("t1_prog_len", int'(prog_len), 4);
      chk("t1_error", int'(error), 0);
      chk("t1_loading_end", int'(loading), 0);

      // Non-command bytes filtered out
      pulse_start();
      chk("t2_done_cleared", int'(done), 0);
      chk("t2_prog_len_cleared", int'(prog_len), 0);
      expect_wr(0, 8'h2B);
      expect_wr(1, 8'h3E);
      expect_wr(2, 8'h00);
      send_str("+ a\n>!");
      wait_end("t2");
      chk("t2_done", int'(done), 1);
      chk("t2_prog_len", int'(prog_len), 2);

      // Overflow: 7 slots for commands, eighth '+' aborts
      pulse_start();
      for (int i = 0; i < 7; i++) expect_wr(i, 8'h2B);
      send_str("++++++++");
      wait_end("t3");
      chk("t3_error", int'(error), 1);
      chk("t3_error_code", int'(error_code), 1);
      chk("t3_done", int'(done), 0);
      chk("t3_loading", int'(loading), 0);
      send_str("+!");
      tick();
      chk("t3_error_held", int'(error), 1);

      // IDLE ignores bytes; start wins over coincident byte
      reset = 1'b1;
      tick();
      reset = 1'b0;
      send_str("+");
      tick();
      chk("t4_idle_loading", int'(loading), 0);
      bus.rx_data  = 8'h2B;
      bus.rx_valid = 1'b1;
      pulse_start();
      bus.rx_valid = 1'b0;
      expect_wr(0, 8'h00);
      send_str("!");
      wait_end("t4");
      chk("t4_done", int'(done), 1);
      chk("t4_prog_len", int'(prog_len), 0);

      // Restart mid-load
      pulse_start();
      expect_wr(0, 8'h2B);
      expect_wr(1, 8'h2B);
      send_str("++");
      chk("t5_loading_mid", int'(loading), 1);
      pulse_start();
      expect_wr(0, 8'h2D);
      expect_wr(1, 8'h00);
      send_str("-!");
      wait_end("t5");
      chk("t5_done", int'(done), 1);
      chk("t5_prog_len", int'(prog_len), 1);

`ifdef BF_LOADER_BRACKET_CHECK_EN
      pulse_start();
      send_str("]!");
      wait_end("t6a");
      chk("t6a_error", int'(error), 1);
      chk("t6a_error_code", int'(error_code), 2);
      pulse_start();
      expect_wr(0, 8'h5B);
      expect_wr(1, 8'h5B);
      expect_wr(2, 8'h5D);
      send_str("[[]!");
      wait_end("t6b");
      chk("t6b_error", int'(error), 1);
      chk("t6b_error_code", int'(error_code), 3);
      chk("t6b_done", int'(done), 0);
`else
      pulse_start();
      expect_wr(0, 8'h5D);
      expect_wr(1, 8'h00);
      send_str("]!");
      wait_end("t6");
      chk("t6_done", int'(done), 1);
      chk("t6_error_code", int'(error_code), 0);
      chk("t6_prog_len", int'(prog_len), 1);
`endif

      tick();
      tick();
      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
